trng_sample_ctrl: RTL and testbench
===================================

# trng_sample_ctrl

Controller that sequences one ring-oscillator entropy source: it gates the ring, waits a warm-up period, samples the asynchronous ring output at a programmable divided rate, and packs samples into words. Words are delivered on a valid/ready handshake. A repetition-count health test stops the ring and latches a failure flag when the source sticks. It sits between the ring oscillator and the TRNG post-processing/bus interface.

## Interface
- WORD_WIDTH, 32, bits per output word (≥2)
- WARMUP_CYCLES, 64, clock cycles the ring runs before the first sample (≥1)
- SAMPLE_DIV, 8, clock cycles between samples (≥1)
- REP_LIMIT, 16, consecutive identical samples that trigger health failure (≥2)

- clk  in  1  system clock
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- enable_i  in  1  level request to run the source
- clear_i  in  1  single-cycle pulse; clears latched health failure
- random_bit  in  1  raw ring output, asynchronous to clk
- RO_enable  out  1  ring gate: 1 = ring held static, 0 = ring oscillates
- data_o  out  WORD_WIDTH  packed random word
- valid_o  out  1  data_o holds a word
- ready_i  in  1  consumer accepts word when valid_o & ready_i
- busy_o  out  1  state ≠ IDLE
- health_fail_o  out  1  sticky repetition-test failure

## Operation
- random_bit passes through a 2-flop synchronizer; only the synchronized value is sampled.
- States: IDLE, WARMUP, SAMPLE, HOLD, FAIL.
- IDLE: RO_enable=1. enable_i=1 → WARMUP; clear warm-up, divider, bit, and repetition counters.
- WARMUP: RO_enable=0; counts WARMUP_CYCLES cycles → SAMPLE. enable_i=0 → IDLE.
- SAMPLE: RO_enable=0; divider counts 0..SAMPLE_DIV-1; when divider = SAMPLE_DIV-1, take sample: shift register ← {shift[WORD_WIDTH-2:0], bit}; bit counter++.
  - On the WORD_WIDTH-th sample: data_o ← completed word, valid_o=1, bit counter=0 → HOLD.
  - enable_i=0 → IDLE; partial word discarded.
- HOLD: ring keeps running; sampling and divider paused; data_o and valid_o stable. On valid_o & ready_i: valid_o=0 next cycle; → SAMPLE with divider=0 if enable_i=1, else → IDLE. enable_i=0 does not drop a pending word.
- Repetition test: counter = 1 on first sample after WARMUP; +1 if sample equals previous sample, else 1. Persists across HOLD and across words; reset only on entering WARMUP. Reaching REP_LIMIT → FAIL (takes priority over word completion on the same sample).
- FAIL: RO_enable=1, valid_o=0, shift register and partial word discarded, health_fail_o=1. Exit only via clear_i (→ IDLE, health_fail_o=0) or rst. enable_i is ignored.
- Counter widths: $clog2 of each parameter range, minimum 1 bit; no wrap beyond terminal values.

## Timing
- Reset values: state IDLE, RO_enable=1, data_o=0, valid_o=0, busy_o=0, health_fail_o=0; all counters and synchronizer flops 0.
- All outputs are registered.
- enable_i sampled high at edge 0 → WARMUP during cycles 1..WARMUP_CYCLES. The k-th sample is taken at the end of cycle WARMUP_CYCLES + k·SAMPLE_DIV.
- First valid_o is high in cycle WARMUP_CYCLES + WORD_WIDTH·SAMPLE_DIV + 1.
- Back-to-back words with ready_i held high: one HOLD cycle, then WORD_WIDTH·SAMPLE_DIV cycles to the next word.
- FAIL is entered the cycle after the offending sample; RO_enable=1 in that same cycle.
- clear_i together with rst: rst wins. clear_i outside FAIL: no effect.
- rst mid-word: everything returns to reset values the next cycle; no partial word is emitted.

## Test plan
All scenarios use WORD_WIDTH=8, WARMUP_CYCLES=4, SAMPLE_DIV=2, REP_LIMIT=4.
- Reset, then idle 10 cycles → RO_enable=1, valid_o=0, busy_o=0, data_o=0, health_fail_o=0.
- enable_i=1; random_bit driven so samples alternate 1,0,1,… → valid_o first high in cycle 21 with data_o=0xAA; ready_i=1 → next word 0xAA valid 17 cycles later.
- Same as previous with ready_i=0 for 10 cycles → data_o=0xAA held, valid_o held high, no samples taken; accepted on ready_i → valid_o=0 next cycle.
- random_bit held constant 1 → FAIL after the 4th sample (cycle 13): RO_enable=1, health_fail_o=1, valid_o never asserts. enable_i toggling → no effect. clear_i pulse → IDLE with health_fail_o=0.
- enable_i dropped after 3 samples → IDLE next cycle. Re-enabling restarts warm-up, and the first word contains no stale bits.
- enable_i dropped during HOLD → word still delivered on ready_i, then IDLE with RO_enable=1.

Source files
------------

// File: rtl/trng_sample_ctrl_if.sv
// Word delivery channel between the TRNG sample controller and its consumer.
// The controller (master) drives the packed word and its valid flag; the
// consumer (slave) answers with ready.
interface trng_sample_ctrl_if #(
    parameter int WORD_WIDTH = 32
) ();
    logic [WORD_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;

    modport master (
        output data_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        output ready_i
    );
endinterface

// File: rtl/trng_sample_ctrl.sv
// Sequencer for one ring-oscillator entropy source: gates the ring, lets it
// warm up, samples the synchronized ring output at a divided rate, packs the
// samples into words and runs a repetition-count health test that parks the
// source in a sticky failure state when the output sticks.
module trng_sample_ctrl #(
    parameter int WORD_WIDTH    = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 8,
    parameter int REP_LIMIT     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic                      random_bit,
    output logic                      RO_enable,
    output logic                      busy_o,
    output logic                      health_fail_o,
    trng_sample_ctrl_if.master        bus
);

    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BIT_W  = $clog2(WORD_WIDTH);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_SAMPLE,
        ST_HOLD,
        ST_FAIL
    } state_t;

    state_t                state_q, state_d;
    logic [WARM_W-1:0]     warm_q, warm_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bitc_q, bitc_d;
    logic [REP_W-1:0]      rep_q, rep_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ro_q, ro_d;
    logic                  busy_q, busy_d;
    logic                  fail_q, fail_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [REP_W-1:0]      rep_next;
    logic [WORD_WIDTH-1:0] shift_next;

    // Next-state, counter and output-register logic; the ring bit only ever
    // enters through the two synchronizer stages before it is used.
    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        div_d      = div_q;
        bitc_d     = bitc_q;
        rep_d      = rep_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        sync1_d    = random_bit;
        sync2_d    = sync1_q;
        shift_next = {shift_q[WORD_WIDTH-2:0], sync2_q};
        if ((rep_q == '0) || (sync2_q != shift_q[0])) begin
            rep_next = REP_W'(1);
        end else begin
            rep_next = rep_q + REP_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_WARMUP;
                    warm_d  = '0;
                    div_d   = '0;
                    bitc_d  = '0;
                    rep_d   = '0;
                    shift_d = '0;
                end
            end
            ST_WARMUP: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (warm_q == WARM_LAST) begin
                    state_d = ST_SAMPLE;
                    div_d   = '0;
                end else begin
                    warm_d = warm_q + WARM_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    shift_d = '0;
                    bitc_d  = '0;
                    div_d   = '0;
                end else if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d   = '0;
                    rep_d   = rep_next;
                    shift_d = shift_next;
                    if (rep_next == REP_MAX) begin
                        state_d = ST_FAIL;
                        shift_d = '0;
                        bitc_d  = '0;
                        valid_d = 1'b0;
                    end else if (bitc_q == BIT_LAST) begin
                        state_d = ST_HOLD;
                        data_d  = shift_next;
                        valid_d = 1'b1;
                        bitc_d  = '0;
                    end else begin
                        bitc_d = bitc_q + BIT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (valid_q && bus.ready_i) begin
                    valid_d = 1'b0;
                    div_d   = '0;
                    state_d = enable_i ? ST_SAMPLE : ST_IDLE;
                end
            end
            ST_FAIL: begin
                valid_d = 1'b0;
                if (clear_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ro_d   = (state_d == ST_IDLE) || (state_d == ST_FAIL);
        busy_d = (state_d != ST_IDLE);
        fail_d = (state_d == ST_FAIL);
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
            div_q   <= '0;
            bitc_q  <= '0;
            rep_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ro_q    <= 1'b1;
            busy_q  <= 1'b0;
            fail_q  <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            div_q   <= div_d;
            bitc_q  <= bitc_d;
            rep_q   <= rep_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ro_q    <= ro_d;
            busy_q  <= busy_d;
            fail_q  <= fail_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign bus.data_o    = data_q;
    assign bus.valid_o   = valid_q;
    assign RO_enable     = ro_q;
    assign busy_o        = busy_q;
    assign health_fail_o = fail_q;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Self-checking bench for trng_sample_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a behavioural model of the sample controller.
module tb_trng_sample_ctrl;

    localparam int NW = 8;
    localparam int WU = 4;
    localparam int SD = 2;
    localparam int RL = 4;

    logic clk = 1'b0;
    logic rst;
    logic enable_i;
    logic clear_i;
    logic random_bit;
    logic RO_enable;
    logic busy_o;
    logic health_fail_o;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    int base = 0;
    int pat = 0;
    logic rb_const = 1'b0;
    int c;

    trng_sample_ctrl_if #(.WORD_WIDTH(NW)) bus ();

    trng_sample_ctrl #(
        .WORD_WIDTH   (NW),
        .WARMUP_CYCLES(WU),
        .SAMPLE_DIV   (SD),
        .REP_LIMIT    (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .clear_i      (clear_i),
        .random_bit   (random_bit),
        .RO_enable    (RO_enable),
        .busy_o       (busy_o),
        .health_fail_o(health_fail_o),
        .bus          (bus)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Behavioural model: source activity, remaining warm-up time, clocks since
    // the last sample, the bits of the word being built and the current run
    // length of identical samples.
    typedef enum {M_IDLE, M_WARM, M_RUN, M_HOLD, M_FAIL} mphase_t;
    mphase_t m_phase;
    int m_warm_left;
    int m_since;
    int m_run;
    bit m_last;
    bit m_bits[$];
    bit m_dly[$];
    logic [NW-1:0] m_word;
    bit m_valid;

    function automatic void modelReset();
        m_phase = M_IDLE;
        m_warm_left = 0;
        m_since = 0;
        m_run = 0;
        m_last = 1'b0;
        m_bits.delete();
        m_dly.delete();
        m_dly.push_back(1'b0);
        m_dly.push_back(1'b0);
        m_word = '0;
        m_valid = 1'b0;
    endfunction

    function automatic void modelStep();
        bit s;
        if (rst) begin
            modelReset();
            return;
        end
        s = m_dly.pop_front();
        m_dly.push_back(random_bit);
        case (m_phase)
            M_IDLE: if (enable_i) begin
                m_phase = M_WARM;
                m_warm_left = WU;
                m_bits.delete();
                m_run = 0;
            end
            M_WARM: if (!enable_i) m_phase = M_IDLE;
            else begin
                m_warm_left--;
                if (m_warm_left == 0) begin
                    m_phase = M_RUN;
                    m_since = 0;
                end
            end
            M_RUN: if (!enable_i) begin
                m_phase = M_IDLE;
                m_bits.delete();
            end else begin
                m_since++;
                if (m_since == SD) begin
                    m_since = 0;
                    m_run = (m_run > 0 && s == m_last) ? m_run + 1 : 1;
                    m_last = s;
                    m_bits.push_back(s);
                    if (m_run >= RL) begin
                        m_phase = M_FAIL;
                        m_bits.delete();
                        m_valid = 1'b0;
                    end else if (m_bits.size() == NW) begin
                        m_word = '0;
                        foreach (m_bits[i]) m_word = {m_word[NW-2:0], m_bits[i]};
                        m_valid = 1'b1;
                        m_bits.delete();
                        m_phase = M_HOLD;
                    end
                end
            end
            M_HOLD: if (bus.ready_i) begin
                m_valid = 1'b0;
                m_since = 0;
                m_phase = enable_i ? M_RUN : M_IDLE;
            end
            M_FAIL: if (clear_i) m_phase = M_IDLE;
            default: m_phase = M_IDLE;
        endcase
    endfunction

    task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, edge_cnt);
        end
    endtask

    task automatic checkOutput();
        checkVal("RO_enable", 32'(RO_enable), 32'(m_phase == M_IDLE || m_phase == M_FAIL));
        checkVal("busy_o", 32'(busy_o), 32'(m_phase != M_IDLE));
        checkVal("health_fail_o", 32'(health_fail_o), 32'(m_phase == M_FAIL));
        checkVal("valid_o", 32'(bus.valid_o), 32'(m_valid));
        if (m_valid) checkVal("data_o", 32'(bus.data_o), 32'(m_word));
    endtask

    task automatic applyStimulus(input logic en, input logic clr, input logic rs, input logic rdy);
        enable_i = en;
        clear_i = clr;
        rst = rs;
        bus.ready_i = rdy;
    endtask

    task automatic tick();
        int t;
        t = edge_cnt + 1;
        case (pat)
            0: random_bit = rb_const;
            1: random_bit = (((t - base) >> 1) & 1) == 0;
            default: random_bit = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        edge_cnt++;
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic waitFlag(input int which, input int limit, output int cyc);
        cyc = -1;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if ((which == 0 && bus.valid_o === 1'b1) || (which == 1 && health_fail_o === 1'b1)) begin
                cyc = n;
                break;
            end
        end
        if (cyc < 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL wait_timeout: got no event expected one within %0d cycles", limit);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        modelReset();
        random_bit = 1'b0;
        pat = 0;
        rb_const = 1'b0;
        doReset();
        repeat (10) tick();
        checkVal("idle_RO_enable", 32'(RO_enable), 32'd1);
        checkVal("idle_valid", 32'(bus.valid_o), 32'd0);
        checkVal("idle_busy", 32'(busy_o), 32'd0);
        checkVal("idle_data", 32'(bus.data_o), 32'd0);
        checkVal("idle_health", 32'(health_fail_o), 32'd0);

        $display("[TB] alternating samples, ready held high");
        pat = 1;
        base = edge_cnt + 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        waitFlag(0, 40, c);
        checkVal("first_valid_cycle", 32'(c), 32'd21);
        checkVal("first_word", 32'(bus.data_o), 32'hAA);
        waitFlag(0, 40, c);
        checkVal("b2b_gap", 32'(c), 32'd17);
        checkVal("second_word", 32'(bus.data_o), 32'hAA);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();

        $display("[TB] consumer stalls for 10 cycles");
        doReset();
        base = edge_cnt + 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitFlag(0, 40, c);
        checkVal("stall_valid_cycle", 32'(c), 32'd21);
        repeat (10) tick();
        checkVal("held_word", 32'(bus.data_o), 32'hAA);
        checkVal("held_valid", 32'(bus.valid_o), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkVal("valid_drop_after_accept", 32'(bus.valid_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();

        $display("[TB] stuck-at-1 source");
        doReset();
        pat = 0;
        rb_const = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        waitFlag(1, 30, c);
        checkVal("fail_cycle", 32'(c), 32'd13);
        checkVal("fail_RO_enable", 32'(RO_enable), 32'd1);
        checkVal("fail_valid", 32'(bus.valid_o), 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'(i & 1), 1'b0, 1'b0, 1'b1);
            tick();
        end
        checkVal("fail_sticky", 32'(health_fail_o), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkVal("clear_health", 32'(health_fail_o), 32'd0);
        checkVal("clear_busy", 32'(busy_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();

        $display("[TB] enable dropped after three samples");
        doReset();
        pat = 0;
        rb_const = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (11) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkVal("drop_busy", 32'(busy_o), 32'd0);
        checkVal("drop_RO_enable", 32'(RO_enable), 32'd1);
        repeat (2) tick();
        pat = 1;
        base = edge_cnt + 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        waitFlag(0, 40, c);
        checkVal("restart_valid_cycle", 32'(c), 32'd21);
        checkVal("restart_word", 32'(bus.data_o), 32'hAA);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();

        $display("[TB] enable dropped while holding a word");
        doReset();
        base = edge_cnt + 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitFlag(0, 40, c);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        checkVal("hold_keeps_valid", 32'(bus.valid_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkVal("hold_release_valid", 32'(bus.valid_o), 32'd0);
        checkVal("hold_release_busy", 32'(busy_o), 32'd0);
        checkVal("hold_release_RO", 32'(RO_enable), 32'd1);

        $display("[TB] randomized traffic");
        pat = 2;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 9) != 0),
                          1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 199) == 0),
                          1'($urandom_range(0, 2) != 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
